demux_rr_dispatch: RTL and testbench
====================================

Name: demux_rr_dispatch

Overview:
- Sequential controller that sits in front of a 1:4 demultiplexer.
- Accepts a single valid/ready input stream and registers each word.
- Chooses a destination channel in round-robin order among enabled channels, then drives the select lines and the one-hot per-channel valid.
- Skips a stalled channel after a programmable timeout, so one slow consumer cannot block the others.

Parameters:
- WIDTH, 8: data word width in bits.
- TIMEOUT, 15: cycles a word waits on a not-ready channel before it is re-routed; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream word available.
- in_data  in  WIDTH  upstream word.
- in_ready  out  1  block accepts the word this cycle.
- ch_mask  in  4  per-channel enable; bit i = channel i eligible.
- out_ready  in  4  per-channel consumer ready.
- out_valid  out  4  one-hot valid to channel sel; all zero when nothing is held.
- out_data  out  WIDTH  held word, broadcast to all channels.
- sel  out  2  current destination channel (demux select).
- skip  out  1  one-cycle pulse when a timeout re-route occurs.
- xfer_cnt  out  16  delivered-word counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clock edge) forces:
  - state=IDLE, ptr=0, sel=0, out_valid=0, out_data=0, skip=0, xfer_cnt=0, wait counter=0.
  - in_ready=0 during the reset cycle.
  - Any held word is discarded when reset is applied mid-operation.
- States: IDLE (nothing held) and HOLD (word held, offered to channel sel).
- pick(p, m): first set bit of m at index p, p+1, p+2, p+3, taken mod 4. Only valid when m≠0.
- in_ready = (m≠0) & (state==IDLE | (state==HOLD & out_ready[sel] & out_valid[sel])). This gives back-to-back throughput of 1 word/cycle.
- Capture: when in_valid & in_ready at an edge:
  - out_data<=in_data, sel<=pick(ptr, ch_mask), state<=HOLD, wait<=0.
  - For the back-to-back case, ptr is the value already advanced past the channel that just completed.
- Transfer: in HOLD with out_ready[sel]=1:
  - Word is delivered at that edge and ptr<=sel+1 (wraps 3→0).
  - If no capture happens in the same cycle, state<=IDLE and out_valid<=0.
- out_valid = (state==HOLD) ? (4'b0001<<sel) : 0. It is registered-state derived, with no combinational path from out_ready.
- Latency: a word captured at edge N is presented on out_valid from cycle N+1.
- Timeout: in HOLD with out_ready[sel]=0, wait increments each cycle. When wait==TIMEOUT-1:
  - sel<=pick(sel+1, ch_mask), wait<=0, skip=1 for one cycle.
  - If sel is the only enabled channel, sel is unchanged but skip still pulses.
- Mask change: in HOLD with ch_mask[sel]=0:
  - Next edge sel<=pick(sel+1, ch_mask), wait<=0, no skip pulse.
  - out_valid is 0 for that cycle, so no transfer is possible.
- ch_mask==0: in_ready=0; a held word stays held (out_valid=0) until some channel is enabled.
- Simultaneous timeout and out_ready[sel] rising: the transfer wins and no skip pulse is generated.
- in_data is never written to out_data unless a capture occurs, so out_data is stable throughout HOLD.

Optional Feature:
- Macro: DEMUX_RR_STATS_EN.
- Defined: xfer_cnt increments by 1 on every delivered word, saturates at 16'hFFFF, and is cleared by reset.
- Not defined: the counter logic is absent and xfer_cnt is tied to 0. The port exists in both builds.

Decomposition:
- Package demux_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - state typedef {IDLE, HOLD}.
  - Function pick(ptr, mask) returning SEL_W bits.
- Sub-module rr_pick: purely combinational round-robin picker (ptr, mask → idx, any). It is instantiated twice: capture pick and re-route pick.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=0, sel=0, xfer_cnt=0, skip=0.
- Round-robin: mask=4'hF, out_ready=4'hF, stream 0xA0..0xA5 back-to-back → sel sequence 0,1,2,3,0,1; one word per cycle; out_valid one-hot matches sel.
- Masked: mask=4'b1010, all ready, send 4 words → delivered on channels 1,3,1,3; out_valid[0] and out_valid[2] never high.
- Timeout: mask=4'hF, out_ready=4'b1110, TIMEOUT=15, send 0x55 with ptr=0 → held on ch0 for 15 cycles, skip pulses once, 0x55 delivered on ch1 the next cycle.
- Mask drop mid-HOLD: word held on ch2 with out_ready[2]=0, clear mask[2] → next cycle sel=3, no skip, word delivered on ch3.
- Stats (DEMUX_RR_STATS_EN defined): deliver 10 words → xfer_cnt=10; in the build without the macro, xfer_cnt=0 throughout.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and the round-robin pick helper for the demux_rr_dispatch block.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // First enabled channel at ptr, ptr+1, ... (mod NUM_CH); returns ptr when mask is empty.
  function automatic logic [SEL_W-1:0] pick(input logic [SEL_W-1:0]  ptr,
                                            input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] result;
    logic             found;
    result = ptr;
    found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && mask[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Combinational round-robin picker: first enabled channel starting at ptr.
module rr_pick
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]  ptr,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  assign idx = pick(ptr, mask);
  assign any = |mask;

endmodule

// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher in front of a 1:4 demux, with stalled-channel timeout re-route.
// Optional delivered-word counter enabled by defining DEMUX_RR_STATS_EN.
module demux_rr_dispatch
  import demux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [SEL_W-1:0]  sel,
  output logic              skip,
  output logic [15:0]       xfer_cnt
);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n;
  logic [7:0]       wait_cnt, wait_n;
  logic [WIDTH-1:0] data_n;
  logic             skip_n;

  logic             hold, sel_en, deliver, capture;
  logic [SEL_W-1:0] sel_inc, ptr_cap, cap_idx, rr_idx;
  logic             cap_any, rr_any;

  assign hold    = (state == HOLD);
  assign sel_en  = ch_mask[sel];
  assign deliver = hold && sel_en && out_ready[sel];
  assign sel_inc = sel + SEL_W'(1);

  // A back-to-back capture must already see ptr advanced past the completing channel.
  assign ptr_cap = deliver ? sel_inc : ptr;

  rr_pick u_cap_pick (.ptr(ptr_cap), .mask(ch_mask), .idx(cap_idx), .any(cap_any));
  rr_pick u_rr_pick  (.ptr(sel_inc), .mask(ch_mask), .idx(rr_idx),  .any(rr_any));

  assign in_ready  = rst_n && cap_any && (!hold || deliver);
  assign capture   = in_valid && in_ready;
  assign out_valid = (hold && sel_en) ? (NUM_CH'(1) << sel) : '0;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    wait_n  = wait_cnt;
    data_n  = out_data;
    skip_n  = 1'b0;

    if (deliver) begin
      ptr_n   = sel_inc;
      state_n = IDLE;
      wait_n  = '0;
    end

    if (capture) begin
      data_n  = in_data;
      sel_n   = cap_idx;
      state_n = HOLD;
      wait_n  = '0;
    end else if (hold && !deliver) begin
      if (!sel_en) begin
        // Destination disabled: move on quietly; with nothing enabled, keep waiting.
        wait_n = '0;
        if (rr_any) sel_n = rr_idx;
      end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
        sel_n  = rr_idx;
        wait_n = '0;
        skip_n = 1'b1;
      end else begin
        wait_n = wait_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      wait_cnt <= '0;
      out_data <= '0;
      skip     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      wait_cnt <= wait_n;
      out_data <= data_n;
      skip     <= skip_n;
    end
  end

`ifdef DEMUX_RR_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (deliver && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Scoreboard bench for demux_rr_dispatch: directed corner cases plus randomized round-robin bursts.
module tb_demux_rr_dispatch;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic [3:0]  ch_mask = 4'hF;
  logic [3:0]  out_ready = 4'hF;
  logic [3:0]  out_valid;
  logic [7:0]  out_data;
  logic [1:0]  sel;
  logic        skip;
  logic [15:0] xfer_cnt;

  demux_rr_dispatch #(.WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ch_mask(ch_mask), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .sel(sel), .skip(skip),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   deliv = 0;
  int   skip_cnt = 0;
  int   model_last = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: words go to enabled channels in cyclic order after the last delivered one.
  function automatic int next_ch(input int last, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (skip) skip_cnt++;
      if (out_valid != 4'b0)
        check("out_valid onehot and enabled",
              {31'b0, ($countones(out_valid) == 1) && ((out_valid & ~ch_mask) == 4'b0)}, 1);
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          deliv++;
          if (exp_q.size() == 0) begin
            check("unexpected delivery", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("deliver channel", c, mon_e.ch);
            check("deliver sel", sel, mon_e.ch);
            check("deliver data", out_data, mon_e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hEE;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("reset out_valid", out_valid, 0);
      check("reset in_ready", in_ready, 0);
      check("reset sel", sel, 0);
      check("reset xfer_cnt", xfer_cnt, 0);
      check("reset skip", skip, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    model_last = 3;
    deliv = 0;
  endtask

  // Entered and left at posedge+1; the expected entry is queued when the handshake is seen.
  task automatic send(input logic [7:0] d, input logic [1:0] ch, output int waits);
    exp_t e;
    bit   ok;
    waits = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        e.ch = ch;
        e.data = d;
        exp_q.push_back(e);
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send handshake timeout", 0, 1);
  endtask

  task automatic send_rr(input logic [7:0] d, output int waits);
    int ch;
    ch = next_ch(model_last, ch_mask);
    model_last = ch;
    send(d, 2'(ch), waits);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && out_valid == 4'b0) idle = 1'b1;
    end
    @(posedge clk); #1;
    if (!idle) check("drain timeout", 0, 1);
  endtask

  task automatic check_cnt(input string name);
`ifdef DEMUX_RR_STATS_EN
    check(name, xfer_cnt, (deliv > 65535) ? 65535 : deliv);
`else
    check(name, xfer_cnt, 0);
`endif
  endtask

  initial begin
    int w, held, s0, n;

    do_reset();

    // Timeout: ch0 never ready, word re-routed to ch1 after TO cycles.
    ch_mask = 4'hF;
    out_ready = 4'b1110;
    s0 = skip_cnt;
    send(8'h55, 2'd1, w);
    held = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid == 4'b0001) held++;
      else break;
    end
    check("timeout hold cycles", held, TO);
    check("skip at reroute", skip, 1);
    check("sel after reroute", sel, 1);
    wait_idle();
    check("skip pulse count", skip_cnt - s0, 1);
    model_last = 1;
    check_cnt("xfer_cnt after timeout");

    // Back-to-back round robin over all channels.
    do_reset();
    ch_mask = 4'hF;
    out_ready = 4'hF;
    for (int i = 0; i < 6; i++) begin
      send_rr(8'hA0 + 8'(i), w);
      if (i > 0) check("back-to-back stall cycles", w, 0);
    end
    wait_idle();
    check_cnt("xfer_cnt after rr");

    // Sparse mask: channels 1 and 3 only.
    do_reset();
    ch_mask = 4'b1010;
    for (int i = 0; i < 4; i++) send_rr(8'hB0 + 8'(i), w);
    wait_idle();
    check_cnt("xfer_cnt after masked");

    // Ten deliveries from reset.
    do_reset();
    ch_mask = 4'hF;
    for (int i = 0; i < 10; i++) send_rr(8'(i * 7 + 1), w);
    wait_idle();
`ifdef DEMUX_RR_STATS_EN
    check("xfer_cnt ten words", xfer_cnt, 10);
`else
    check("xfer_cnt ten words", xfer_cnt, 0);
`endif

    // Mask drop while held on ch2.
    do_reset();
    ch_mask = 4'hF;
    out_ready = 4'hF;
    send_rr(8'h11, w);
    send_rr(8'h22, w);
    wait_idle();
    out_ready = 4'b0000;
    send(8'h33, 2'd3, w);
    @(negedge clk);
    check("held on ch2", out_valid, 4'b0100);
    @(posedge clk); #1;
    ch_mask = 4'b1011;
    out_ready = 4'b1000;
    s0 = skip_cnt;
    @(negedge clk);
    check("valid low after mask drop", out_valid, 0);
    @(negedge clk);
    check("sel moved to ch3", sel, 3);
    check("no skip on mask drop", skip, 0);
    wait_idle();
    check("skip count mask drop", skip_cnt - s0, 0);
    model_last = 3;

    // All channels disabled while holding: word parked, no new input accepted.
    do_reset();
    ch_mask = 4'hF;
    out_ready = 4'h0;
    send(8'h66, 2'd2, w);
    @(posedge clk); #1;
    ch_mask = 4'h0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mask zero in_ready", in_ready, 0);
      check("mask zero out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ch_mask = 4'b0100;
    out_ready = 4'hF;
    wait_idle();
    model_last = 2;

    // Reset mid-hold discards the word.
    ch_mask = 4'hF;
    out_ready = 4'h0;
    send_rr(8'h77, w);
    repeat (3) @(posedge clk);
    do_reset();
    out_ready = 4'hF;
    repeat (4) begin
      @(negedge clk);
      check("no word after reset", out_valid, 0);
    end
    @(posedge clk); #1;

    // Randomized bursts: random enabled set, all enabled consumers ready.
    for (int b = 0; b < 20; b++) begin
      wait_idle();
      ch_mask = 4'($urandom_range(1, 15));
      out_ready = ch_mask | 4'($urandom);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_rr(8'($urandom), w);
      end
    end
    wait_idle();
    check_cnt("xfer_cnt after random");
    check("scoreboard empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
